johnson_phase_tracker: RTL
==========================

// Module: johnson_phase_tracker
// PURPOSE
//   Downstream consumer of the Johnson counter: samples its count bus each clock,
//   checks legality, decodes to binary phase index and one-hot phase strobe, and
//   runs a lock FSM that flags illegal codes and out-of-sequence steps.
//   Feeds phase-sequenced logic that must only act on a verified counter.
// PARAMETERS
//   WIDTH     4  Johnson count width; sequence length 2*WIDTH
//   LOCK_CNT  4  consecutive +1 steps required to enter LOCKED (>=1)
//   ERR_CNT_W 8  width of saturating error counter
// PORTS
//   clk           in   1                   rising-edge clock
//   reset_n       in   1                   synchronous, active-low reset
//   count_in      in   WIDTH               Johnson code from upstream counter
//   err_clr       in   1                   synchronous clear of err_count
//   phase_idx     out  $clog2(2*WIDTH)     decoded phase index
//   phase_onehot  out  2*WIDTH             one-hot of phase_idx; 0 when invalid
//   phase_valid   out  1                   last sample was a legal code
//   locked        out  1                   FSM in LOCKED
//   illegal_err   out  1                   1-cycle pulse: illegal code sampled
//   seq_err       out  1                   1-cycle pulse: legal code, bad step
//   wrap_pulse    out  1                   1-cycle pulse: idx 2W-1 -> 0 while locked
//   err_count     out  ERR_CNT_W           saturating error count
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low. reset_n=0 at an edge: all
//     outputs 0, FSM=ACQUIRE, run count 0, have_prev 0. Reset wins over all.
//   - Legal: at most one i in [0,WIDTH-2] with count_in[i]!=count_in[i+1]
//     (exactly 2*WIDTH codes). Index: bit0=1 -> popcount; else (2W-popcount) mod 2W.
//     WIDTH=4: 0000=0,0001=1,0011=2,0111=3,1111=4,1110=5,1100=6,1000=7.
//   - Latency 1: all outputs registered, reflect count_in sampled at prior edge.
//   - Illegal sample: phase_valid=0, onehot=0, phase_idx holds last legal value,
//     illegal_err=1, have_prev<=0, run<=0.
//   - Legal sample, have_prev=0: outputs update, no step check, have_prev<=1.
//   - Legal, have_prev=1, step vs previous idx: same -> hold (run unchanged);
//     +1 mod 2W -> advance (run++ saturating at LOCK_CNT); else seq_err=1, run<=0.
//   - FSM ACQUIRE -> LOCKED on the edge registering the LOCK_CNT-th consecutive
//     advance (locked rises with that sample's phase_idx). LOCKED -> ACQUIRE on
//     any illegal_err or seq_err (same edge). Hold steps never break lock.
//   - wrap_pulse only in LOCKED (before the edge) on advance 2W-1 -> 0.
//   - err_count: +1 per cycle with illegal_err|seq_err (max +1/cycle), saturates
//     at 2^ERR_CNT_W-1. err_clr same cycle as error -> result 0 (clear wins).
// STRUCTURE
//   - Package johnson_pkg: FSM enum {ACQUIRE, LOCKED}; functions
//     johnson_legal(code), johnson_idx(code) parameterised by WIDTH.
//   - Sub-module johnson_decode: combinational legal/idx/onehot from count_in;
//     top holds sample regs, step compare, run counter, FSM, err counter.
// TESTING (WIDTH=4, LOCK_CNT=4, 10 ns clock)
//   1 reset_n=0 two edges, count_in=0101 -> all outputs 0, locked=0, err_count=0.
//   2 after reset feed 0000,0001,0011,0111,1111 -> phase_idx 0..4 one cycle late,
//     locked=1 with phase_idx=4, no error pulses, onehot=8'h10.
//   3 continue 1110,1100,1000,0000 -> idx 5,6,7,0; wrap_pulse exactly once (7->0).
//   4 locked, inject 0101 -> illegal_err 1 cycle, phase_valid=0, idx holds 0,
//     locked=0, err_count=1; then 0001 next -> no seq_err (have_prev cleared).
//   5 0011,0011,1100 -> hold gives no error; jump 2->6 gives seq_err, err_count+1;
//     error and err_clr same cycle -> err_count=0.
//   6 reset_n=0 one edge while locked -> all outputs 0 next cycle; ERR_CNT_W=2 run
//     with 5 illegal codes -> err_count saturates at 3.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and Johnson-code helpers for the phase tracker.
// Helpers take the code zero-extended to MAX_W bits plus the live width.
package johnson_pkg;

  localparam int MAX_W = 32;

  typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} lock_state_e;

  // Legal Johnson code: at most one adjacent-bit transition inside the width.
  function automatic logic johnson_legal(input logic [MAX_W-1:0] code, input int w);
    int t;
    t = 0;
    for (int i = 0; i < MAX_W-1; i++) begin
      if ((i < w-1) && (code[i] != code[i+1])) t++;
    end
    return (t <= 1);
  endfunction

  // Phase index of a legal code: filling ones count up, draining ones count down.
  function automatic int johnson_idx(input logic [MAX_W-1:0] code, input int w);
    int p;
    p = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i < w) && code[i]) p++;
    end
    if (code[0])     return p;
    else if (p == 0) return 0;
    else             return 2*w - p;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of a Johnson count: legality, phase index, one-hot strobe.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]           count_in,
  output logic                       legal,
  output logic [$clog2(2*WIDTH)-1:0] idx,
  output logic [2*WIDTH-1:0]         onehot
);

  localparam int IDX_W = $clog2(2*WIDTH);

  logic [MAX_W-1:0] code_ext;

  always_comb begin
    code_ext               = '0;
    code_ext[WIDTH-1:0]    = count_in;
    legal                  = johnson_legal(code_ext, WIDTH);
    idx                    = IDX_W'(johnson_idx(code_ext, WIDTH));
    onehot                 = '0;
    if (legal) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Samples an upstream Johnson counter, decodes phase, checks step sequence and
// tracks lock; all outputs are registered one clock after the sample.
module johnson_phase_tracker
  import johnson_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       err_clr,
  output logic [$clog2(2*WIDTH)-1:0] phase_idx,
  output logic [2*WIDTH-1:0]         phase_onehot,
  output logic                       phase_valid,
  output logic                       locked,
  output logic                       illegal_err,
  output logic                       seq_err,
  output logic                       wrap_pulse,
  output logic [ERR_CNT_W-1:0]       err_count
);

  localparam int IDX_W = $clog2(2*WIDTH);
  localparam int RUN_W = $clog2(LOCK_CNT+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2*WIDTH-1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_CNT);

  logic                 dec_legal;
  logic [IDX_W-1:0]     dec_idx;
  logic [2*WIDTH-1:0]   dec_onehot;

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .count_in (count_in),
    .legal    (dec_legal),
    .idx      (dec_idx),
    .onehot   (dec_onehot)
  );

  lock_state_e          state_q, state_d;
  logic [IDX_W-1:0]     phase_idx_q, phase_idx_d;
  logic [2*WIDTH-1:0]   phase_onehot_q, phase_onehot_d;
  logic                 phase_valid_q, phase_valid_d;
  logic                 illegal_err_q, illegal_err_d;
  logic                 seq_err_q, seq_err_d;
  logic                 wrap_pulse_q, wrap_pulse_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 have_prev_q, have_prev_d;
  logic [RUN_W-1:0]     run_q, run_d;

  logic [IDX_W-1:0]     idx_plus1;
  logic                 step_adv;

  // Step classification against the last legal index held in phase_idx_q.
  always_comb begin
    idx_plus1      = (phase_idx_q == LAST_IDX) ? '0 : phase_idx_q + IDX_W'(1);
    step_adv       = 1'b0;
    phase_idx_d    = phase_idx_q;
    phase_onehot_d = '0;
    phase_valid_d  = 1'b0;
    illegal_err_d  = 1'b0;
    seq_err_d      = 1'b0;
    wrap_pulse_d   = 1'b0;
    have_prev_d    = 1'b0;
    run_d          = '0;
    if (dec_legal) begin
      phase_idx_d    = dec_idx;
      phase_onehot_d = dec_onehot;
      phase_valid_d  = 1'b1;
      have_prev_d    = 1'b1;
      run_d          = run_q;
      if (have_prev_q) begin
        if (dec_idx == idx_plus1) begin
          step_adv     = 1'b1;
          run_d        = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
          wrap_pulse_d = (state_q == LOCKED) && (phase_idx_q == LAST_IDX);
        end else if (dec_idx != phase_idx_q) begin
          seq_err_d = 1'b1;
          run_d     = '0;
        end
      end
    end else begin
      illegal_err_d = 1'b1;
    end
  end

  // Clear has priority over a same-cycle error increment.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr)
      err_count_d = '0;
    else if ((illegal_err_d || seq_err_d) && (err_count_q != '1))
      err_count_d = err_count_q + ERR_CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACQUIRE: if (step_adv && (run_d == RUN_MAX)) state_d = LOCKED;
      LOCKED:  if (illegal_err_d || seq_err_d)     state_d = ACQUIRE;
      default: state_d = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ACQUIRE;
    else          state_q <= state_d;
  end

  always_comb begin
    locked = (state_q == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_idx_q    <= '0;
      phase_onehot_q <= '0;
      phase_valid_q  <= 1'b0;
      illegal_err_q  <= 1'b0;
      seq_err_q      <= 1'b0;
      wrap_pulse_q   <= 1'b0;
      err_count_q    <= '0;
      have_prev_q    <= 1'b0;
      run_q          <= '0;
    end else begin
      phase_idx_q    <= phase_idx_d;
      phase_onehot_q <= phase_onehot_d;
      phase_valid_q  <= phase_valid_d;
      illegal_err_q  <= illegal_err_d;
      seq_err_q      <= seq_err_d;
      wrap_pulse_q   <= wrap_pulse_d;
      err_count_q    <= err_count_d;
      have_prev_q    <= have_prev_d;
      run_q          <= run_d;
    end
  end

  assign phase_idx    = phase_idx_q;
  assign phase_onehot = phase_onehot_q;
  assign phase_valid  = phase_valid_q;
  assign illegal_err  = illegal_err_q;
  assign seq_err      = seq_err_q;
  assign wrap_pulse   = wrap_pulse_q;
  assign err_count    = err_count_q;

endmodule
